// File: rtl/controller_tx_pkg.sv
// Shared types and constants for the cognitive-radio transmit controller.
// Lanes are packed low-lane-first on every multi-lane bus.
package controller_tx_pkg;

    localparam int DEF_D_LEN = 100;
    localparam int DEF_N_CH  = 3;
    localparam int U_W       = 2;

    typedef enum logic {IDLE, SEND} lane_state_t;

    typedef struct packed {
        logic           l;
        logic [U_W-1:0] u;
        logic           d;
        logic           valid;
        logic           sof;
        logic           eof;
    } lane_out_t;

    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/controller_tx_lane.sv
// One transmit lane: captures a licensed word and two secondary words, then
// serialises them LSB-first, mapping secondary data onto the licensed lane when d=0.
module controller_tx_lane
    import controller_tx_pkg::*;
#(
    parameter int D_LEN = DEF_D_LEN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [D_LEN-1:0] l_word,
    input  logic [D_LEN-1:0] ua_word,
    input  logic [D_LEN-1:0] ub_word,
    input  logic             d,
    output logic             l_tx,
    output logic [U_W-1:0]   u_tx,
    output logic             d_tx,
    output logic             tx_valid,
    output logic             sof,
    output logic             eof
);

    localparam int            CW   = $clog2(D_LEN);
    localparam logic [CW-1:0] LAST = CW'(D_LEN - 1);

    lane_state_t      state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [D_LEN-1:0] l_sr_q, l_sr_d;
    logic [D_LEN-1:0] ua_sr_q, ua_sr_d;
    logic [D_LEN-1:0] ub_sr_q, ub_sr_d;
    lane_out_t        out_q, out_d;
    logic             accept;

    assign ld_ready = (state_q == IDLE) || (cnt_q == LAST);
    assign accept   = ld_valid && ld_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        l_sr_d  = l_sr_q;
        ua_sr_d = ua_sr_q;
        ub_sr_d = ub_sr_q;
        out_d   = '0;

        if (state_q == SEND) begin
            out_d.valid = 1'b1;
            out_d.sof   = (cnt_q == '0);
            out_d.eof   = (cnt_q == LAST);
            out_d.d     = d;
            // Primary idle: word B borrows the licensed lane, its own slot goes quiet.
            if (d) begin
                out_d.l = l_sr_q[0];
                out_d.u = {ub_sr_q[0], ua_sr_q[0]};
            end else begin
                out_d.l = ub_sr_q[0];
                out_d.u = {1'b0, ua_sr_q[0]};
            end
            l_sr_d  = l_sr_q >> 1;
            ua_sr_d = ua_sr_q >> 1;
            ub_sr_d = ub_sr_q >> 1;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST)
                state_d = IDLE;
        end

        // The last bit above was taken from the old registers, so loading here is safe.
        if (accept) begin
            l_sr_d  = l_word;
            ua_sr_d = ua_word;
            ub_sr_d = ub_word;
            cnt_d   = '0;
            state_d = SEND;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            l_sr_q  <= '0;
            ua_sr_q <= '0;
            ub_sr_q <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            l_sr_q  <= l_sr_d;
            ua_sr_q <= ua_sr_d;
            ub_sr_q <= ub_sr_d;
            out_q   <= out_d;
        end
    end

    assign l_tx     = out_q.l;
    assign u_tx     = out_q.u;
    assign d_tx     = out_q.d;
    assign tx_valid = out_q.valid;
    assign sof      = out_q.sof;
    assign eof      = out_q.eof;

endmodule

// File: rtl/controller_transmitter.sv
// N_CH independent transmit lanes; this level only slices the packed buses.
module controller_transmitter
    import controller_tx_pkg::*;
#(
    parameter int D_LEN = DEF_D_LEN,
    parameter int N_CH  = DEF_N_CH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH-1:0]       ld_valid,
    output logic [N_CH-1:0]       ld_ready,
    input  logic [N_CH*D_LEN-1:0] l_word,
    input  logic [N_CH*D_LEN-1:0] ua_word,
    input  logic [N_CH*D_LEN-1:0] ub_word,
    input  logic [N_CH-1:0]       d,
    output logic [N_CH-1:0]       l_tx,
    output logic [U_W*N_CH-1:0]   u_tx,
    output logic [N_CH-1:0]       d_tx,
    output logic [N_CH-1:0]       tx_valid,
    output logic [N_CH-1:0]       sof,
    output logic [N_CH-1:0]       eof
);

    for (genvar c = 0; c < N_CH; c++) begin : g_lane
        controller_tx_lane #(.D_LEN(D_LEN)) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .ld_valid (ld_valid[c]),
            .ld_ready (ld_ready[c]),
            .l_word   (l_word[lane_lsb(c, D_LEN) +: D_LEN]),
            .ua_word  (ua_word[lane_lsb(c, D_LEN) +: D_LEN]),
            .ub_word  (ub_word[lane_lsb(c, D_LEN) +: D_LEN]),
            .d        (d[c]),
            .l_tx     (l_tx[c]),
            .u_tx     (u_tx[lane_lsb(c, U_W) +: U_W]),
            .d_tx     (d_tx[c]),
            .tx_valid (tx_valid[c]),
            .sof      (sof[c]),
            .eof      (eof[c])
        );
    end

endmodule

// File: tb/tb_controller_transmitter.sv
// Scoreboard bench for controller_transmitter with D_LEN=8, N_CH=3.
// Drivers push per-bit expectations; a negedge monitor pops and compares.
module tb_controller_transmitter;

    localparam int D = 8;
    localparam int N = 3;

    typedef struct packed {
        logic       l;
        logic [1:0] u;
        logic       d;
        logic       sof;
        logic       eof;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   ld_valid, ld_ready, d, l_tx, d_tx, tx_valid, sof, eof;
    logic [N*D-1:0] l_word, ua_word, ub_word;
    logic [2*N-1:0] u_tx;

    int total = 0;
    int bad   = 0;

    exp_t q0[$], q1[$], q2[$];
    logic [7:0] cap_l[N], cap_u0[N], cap_u1[N];
    int         run[N], max_run[N];

    always #5 clk = ~clk;

    controller_transmitter #(.D_LEN(D), .N_CH(N)) dut (
        .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .l_word(l_word), .ua_word(ua_word), .ub_word(ub_word), .d(d),
        .l_tx(l_tx), .u_tx(u_tx), .d_tx(d_tx), .tx_valid(tx_valid),
        .sof(sof), .eof(eof)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] l, input logic [7:0] ua,
                                input logic [7:0] ub, input logic dd, input int k);
        exp_t e;
        e.l   = dd ? l[k] : ub[k];
        e.u   = dd ? {ub[k], ua[k]} : {1'b0, ua[k]};
        e.d   = dd;
        e.sof = (k == 0);
        e.eof = (k == D - 1);
        return e;
    endfunction

    function automatic void push(input int c, input exp_t e);
        case (c)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    function automatic int qsize(input int c);
        case (c)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t pop(input int c);
        case (c)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    // Monitor: every valid bit must match the head of its lane queue; idle lanes read 0.
    always @(negedge clk) begin
        exp_t act, e;
        if (rst_n) begin
            for (int c = 0; c < N; c++) begin
                act = {l_tx[c], u_tx[2*c +: 2], d_tx[c], sof[c], eof[c]};
                if (tx_valid[c]) begin
                    run[c]++;
                    if (run[c] > max_run[c]) max_run[c] = run[c];
                    cap_l[c]  = {l_tx[c], cap_l[c][7:1]};
                    cap_u0[c] = {u_tx[2*c], cap_u0[c][7:1]};
                    cap_u1[c] = {u_tx[2*c+1], cap_u1[c][7:1]};
                    if (qsize(c) == 0) chk($sformatf("unexpected_bit_lane%0d", c), 1, 0);
                    else begin
                        e = pop(c);
                        chk($sformatf("bit_lane%0d", c), 32'(act), 32'(e));
                    end
                end else begin
                    run[c] = 0;
                    chk($sformatf("idle_zero_lane%0d", c), 32'(act), 0);
                end
            end
        end
    end

    // Issue one frame on lane c; returns at the time the last bit is set up
    // (before its emitting edge) so a following call chains gap-free.
    task automatic issue(input int c, input logic [7:0] l, input logic [7:0] ua,
                         input logic [7:0] ub, input logic [7:0] dp,
                         input int abort_k, output int waits);
        l_word[c*D +: D]  = l;
        ua_word[c*D +: D] = ua;
        ub_word[c*D +: D] = ub;
        ld_valid[c] = 1'b1;
        waits = 0;
        forever begin
            @(negedge clk);
            if (ld_ready[c]) break;
            waits++;
            if (waits > 40) break;
        end
        if (waits > 40) begin
            chk($sformatf("accept_timeout_lane%0d", c), 1, 0);
            ld_valid[c] = 1'b0;
            return;
        end
        @(posedge clk); #1;
        ld_valid[c] = 1'b0;
        for (int k = 0; k < D; k++) begin
            if (k == abort_k) return;
            chk($sformatf("ld_ready_lane%0d_k%0d", c, k), 32'(ld_ready[c]), 32'(k == D - 1));
            d[c] = dp[k];
            push(c, mk(l, ua, ub, dp[k], k));
            if (k < D - 1) begin @(posedge clk); #1; end
        end
    endtask

    task automatic drain();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic chk_caps(input string tag, input int c, input logic [7:0] el,
                            input logic [7:0] eu0, input logic [7:0] eu1);
        chk({tag, "_l"}, 32'(cap_l[c]), 32'(el));
        chk({tag, "_u0"}, 32'(cap_u0[c]), 32'(eu0));
        chk({tag, "_u1"}, 32'(cap_u1[c]), 32'(eu1));
    endtask

    initial begin
        int w0, w1, w2;
        rst_n = 1'b0; ld_valid = '0; d = '0;
        l_word = '0; ua_word = '0; ub_word = '0;
        for (int c = 0; c < N; c++) begin
            cap_l[c] = '0; cap_u0[c] = '0; cap_u1[c] = '0; run[c] = 0; max_run[c] = 0;
        end
        #1;
        chk("reset_outputs", {tx_valid, l_tx, u_tx, d_tx, sof, eof}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("post_reset_ready", 32'(ld_ready), 32'h7);
        chk("post_reset_valid", 32'(tx_valid), 0);

        // Primary present: streams equal the raw words.
        issue(0, 8'hA5, 8'h0F, 8'hF0, 8'hFF, -1, w0);
        drain();
        chk_caps("d1_map", 0, 8'hA5, 8'h0F, 8'hF0);

        // Primary idle: licensed lane carries word B.
        issue(0, 8'hA5, 8'h0F, 8'hF0, 8'h00, -1, w0);
        drain();
        chk_caps("d0_map", 0, 8'hF0, 8'h0F, 8'h00);

        // d toggling from 1: hand-derived l stream 0x96, u1 stream 0x41.
        issue(0, 8'h3C, 8'h99, 8'hC3, 8'h55, -1, w0);
        drain();
        chk_caps("d_toggle", 0, 8'h96, 8'h99, 8'h41);

        // Back-to-back frames: second accept lands on the eof edge.
        max_run[0] = 0;
        issue(0, 8'hA5, 8'h0F, 8'hF0, 8'hFF, -1, w0);
        issue(0, 8'h3C, 8'h99, 8'hC3, 8'h00, -1, w1);
        chk("b2b_accept_wait", 32'(w1), 0);
        drain();
        chk("b2b_run_len", 32'(max_run[0]), 16);
        chk_caps("b2b_second", 0, 8'hC3, 8'h99, 8'h00);

        // Independent lanes, staggered 0/3/5 cycles, different decisions.
        fork
            issue(0, 8'h11, 8'h22, 8'h33, 8'hFF, -1, w0);
            begin repeat (3) @(posedge clk); #1; issue(1, 8'h44, 8'h55, 8'h66, 8'h00, -1, w1); end
            begin repeat (5) @(posedge clk); #1; issue(2, 8'h77, 8'h88, 8'h99, 8'hF0, -1, w2); end
        join
        drain();
        chk_caps("indep_lane0", 0, 8'h11, 8'h22, 8'h33);
        chk_caps("indep_lane1", 1, 8'h66, 8'h55, 8'h00);
        chk_caps("indep_lane2", 2, 8'h79, 8'h88, 8'h90);

        // Reset while lane 1 shows bit 3.
        issue(1, 8'hA5, 8'h0F, 8'hF0, 8'hFF, 4, w1);
        chk("abort_bit3_valid", 32'(tx_valid[1]), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_outputs_clear", {tx_valid, l_tx, u_tx, d_tx, sof, eof}, 0);
        q1.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("abort_release_ready", 32'(ld_ready), 32'h7);
        chk("abort_release_valid", 32'(tx_valid), 0);
        issue(1, 8'h3C, 8'h99, 8'hC3, 8'hFF, -1, w1);
        drain();
        chk_caps("after_abort", 1, 8'h3C, 8'h99, 8'hC3);

        chk("queues_empty", 32'(q0.size() + q1.size() + q2.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/controller_transmitter.md
Name: controller_transmitter

Overview:
- Transmit-side cognitive-radio channel controller with N_CH independent lanes.
- Each lane accepts one licensed (primary) word and two secondary words per frame through a valid/ready load handshake.
- It then serialises them LSB-first, one bit index per clock, onto a 1-bit licensed lane and a 2-bit secondary lane.
- A per-bit spectrum decision d picks the mapping, so secondary data rides the licensed lane whenever the primary user is idle. A matching receiver demultiplexes the lanes using the echoed d_tx.

Parameters:
- D_LEN, 100, bits per word, which is also the number of bit periods per frame (must be >= 2).
- N_CH, 3, number of independent channels/lanes.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ld_valid  in  N_CH  per-lane load request.
- ld_ready  out  N_CH  per-lane load accept.
- l_word  in  N_CH*D_LEN  licensed words; lane c occupies [c*D_LEN +: D_LEN].
- ua_word  in  N_CH*D_LEN  secondary word A per lane, same packing.
- ub_word  in  N_CH*D_LEN  secondary word B per lane, same packing.
- d  in  N_CH  per-lane decision: 1 = primary user present, 0 = primary idle.
- l_tx  out  N_CH  licensed-lane bit.
- u_tx  out  2*N_CH  secondary-lane bits; lane c occupies [2c +: 2].
- d_tx  out  N_CH  decision applied to the current output bit.
- tx_valid  out  N_CH  output bit valid.
- sof  out  N_CH  high with bit 0 of a frame.
- eof  out  N_CH  high with bit D_LEN-1 of a frame.

Behaviour:
- Lanes are fully independent. Everything below applies per lane.
- Reset (async, rst_n=0):
  - state=IDLE, cnt=0, shift registers=0.
  - l_tx, u_tx, d_tx, tx_valid, sof, eof = 0, asserted immediately.
  - No capture is possible while rst_n=0.
- States: IDLE and SEND. cnt is the index of the next bit to emit, width $clog2(D_LEN).
- ld_ready is combinational: 1 in IDLE, or in SEND when cnt==D_LEN-1, otherwise 0.
- Accept occurs on any edge where ld_valid & ld_ready:
  - Capture l/ua/ub words.
  - cnt <= 0.
  - state <= SEND.
- While SEND is active, every edge registers the bit at index k=cnt, using d sampled at that same edge:
  - d=1: l_tx=l[k]; u_tx={ub[k], ua[k]}; d_tx=1.
  - d=0: l_tx=ub[k]; u_tx={1'b0, ua[k]}; d_tx=0. Licensed bit l[k] is discarded.
  - tx_valid=1; sof=(k==0); eof=(k==D_LEN-1).
  - cnt++.
- Latency: first bit appears on outputs after the edge following accept. A frame gives exactly D_LEN consecutive tx_valid cycles.
- End of frame, on the edge that emits k=D_LEN-1:
  - If there is a simultaneous accept, capture new words, cnt<=0, stay in SEND. The next edge emits bit 0 of the new frame, so frames run gap-free.
  - Otherwise state <= IDLE. The following edge clears tx_valid, sof, eof, l_tx, u_tx and d_tx to 0.
- Emitting the last bit reads the old words; capture writes the new ones. This swap must be race-free.
- ld_valid while ld_ready=0 is ignored. The source holds its words until accepted.
- d may change on any cycle; it affects only the bit emitted at that edge.
- Reset mid-frame aborts the frame with no partial completion. After release, the lane is in IDLE and the next frame starts at bit 0.
- Output bits are held between frames as 0, never as stale data.

Decomposition:
- Package controller_tx_pkg holds:
  - lane_state_t enum {IDLE, SEND}.
  - Default D_LEN and N_CH localparams.
  - Lane slice helper constants.
- Sub-module controller_tx_lane contains the single-lane FSM, counter and shift registers. The top instantiates it N_CH times in a generate loop and only slices the buses.

Test Plan:
- Reset check: assert rst_n=0 mid-simulation -> all outputs 0 the same cycle; after release, ld_ready=3'b111 and tx_valid=0.
- Licensed-present mapping: D_LEN=8, d=1, l=0xA5, ua=0x0F, ub=0xF0 -> over 8 cycles:
  - l_tx = 1,0,1,0,0,1,0,1.
  - u_tx[0] = 1,1,1,1,0,0,0,0 and u_tx[1] = 0,0,0,0,1,1,1,1.
  - sof on cycle 1, eof on cycle 8, d_tx=1 throughout.
- Licensed-idle mapping: same words with d=0 -> l_tx = 0,0,0,0,1,1,1,1; u_tx[1]=0; u_tx[0] as above; d_tx=0.
- d toggled every cycle, starting with d=1 -> l_tx alternates between l[k] and ub[k]; d_tx tracks d one edge later.
- Back-to-back frames: D_LEN=8 with ld_valid held high for two frames -> 16 contiguous tx_valid cycles, eof on bit 7 and sof on the next cycle, ld_ready pulses only at cnt==7.
- Lane independence and reset abort: lanes 0/1/2 start 0/3/5 cycles apart with differing d -> each stream matches the lane model. Then drop rst_n during lane 1 bit 3 -> outputs clear immediately, and the next accepted frame begins at bit 0 with sof.
